// File: rtl/line_burst_adaptor_if.sv
`default_nettype none
// ============================================================================
// Module   : line_burst_adaptor_if
// Purpose  : Cache line port plus memory burst port of the line/burst adaptor.
// Revision : 1.0
// ============================================================================
interface line_burst_adaptor_if #(
  parameter int BEAT_W = 64,
  parameter int BEATS  = 4
);
  logic                      line_read_i;
  logic                      line_write_i;
  logic [31:0]               line_addr_i;
  logic [BEAT_W*BEATS-1:0]   line_wdata_i;
  logic [BEAT_W*BEATS-1:0]   line_rdata_o;
  logic                      line_resp_o;
  logic                      burst_read_o;
  logic                      burst_write_o;
  logic [31:0]               burst_addr_o;
  logic [BEAT_W-1:0]         burst_wdata_o;
  logic [BEAT_W-1:0]         burst_rdata_i;
  logic                      burst_resp_i;

  // The adaptor answers the cache and drives the memory burst port.
  modport slave (
    input  line_read_i, line_write_i, line_addr_i, line_wdata_i,
    input  burst_rdata_i, burst_resp_i,
    output line_rdata_o, line_resp_o,
    output burst_read_o, burst_write_o, burst_addr_o, burst_wdata_o
  );

  modport master (
    output line_read_i, line_write_i, line_addr_i, line_wdata_i,
    output burst_rdata_i, burst_resp_i,
    input  line_rdata_o, line_resp_o,
    input  burst_read_o, burst_write_o, burst_addr_o, burst_wdata_o
  );
endinterface
`default_nettype wire

// File: rtl/line_burst_adaptor.sv
`default_nettype none
// ============================================================================
// Module   : line_burst_adaptor
// Purpose  : Turns one cache line read/write into a BEATS-beat memory burst.
// Revision : 1.0
// ============================================================================
module line_burst_adaptor #(
  parameter int BEAT_W = 64,
  parameter int BEATS  = 4,
  parameter int OFFS   = 5
) (
  input  wire logic              clk,
  input  wire logic              rst,
  line_burst_adaptor_if.slave    bus
);
  localparam int LINE_W = BEAT_W * BEATS;
  localparam int CNT_W  = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   beat_q,  beat_d;
  logic [31:0]        addr_q,  addr_d;
  logic [LINE_W-1:0]  line_q,  line_d;
  logic [LINE_W-1:0]  rline_q, rline_d;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^bus.line_addr_i[OFFS-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      rline_q <= rline_d;
    end
  end

  // line_q is the write line during a write and the assembly buffer during a
  // read; rline_q only changes on the last read beat so the cache sees a
  // stable line until the next read completes.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    line_d  = line_q;
    rline_d = rline_q;
    case (state_q)
      IDLE: begin
        if (bus.line_read_i) begin
          addr_d  = {bus.line_addr_i[31:OFFS], {OFFS{1'b0}}};
          line_d  = '0;
          state_d = RD_BURST;
        end else if (bus.line_write_i) begin
          addr_d  = {bus.line_addr_i[31:OFFS], {OFFS{1'b0}}};
          line_d  = bus.line_wdata_i;
          state_d = WR_BURST;
        end
      end
      RD_BURST: begin
        if (bus.burst_resp_i) begin
          line_d[beat_q*BEAT_W +: BEAT_W] = bus.burst_rdata_i;
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            rline_d = line_d;
            state_d = DONE;
          end
        end
      end
      WR_BURST: begin
        if (bus.burst_resp_i) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        beat_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.line_resp_o   = (state_q == DONE);
  assign bus.line_rdata_o  = rline_q;
  assign bus.burst_read_o  = (state_q == RD_BURST);
  assign bus.burst_write_o = (state_q == WR_BURST);
  assign bus.burst_addr_o  = addr_q;
  assign bus.burst_wdata_o = (state_q == WR_BURST) ? line_q[beat_q*BEAT_W +: BEAT_W]
                                                   : '0;
endmodule
`default_nettype wire

// File: tb/tb_line_burst_adaptor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_line_burst_adaptor
// Purpose  : Randomised scoreboard bench for line_burst_adaptor.
// Revision : 1.0
// ============================================================================
module tb_line_burst_adaptor;
  localparam int BW = 64;
  localparam int NB = 4;
  localparam int LW = BW * NB;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  line_burst_adaptor_if #(.BEAT_W(BW), .BEATS(NB)) bus();

  line_burst_adaptor #(.BEAT_W(BW), .BEATS(NB), .OFFS(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [LW-1:0] wdata;
  } txn_t;

  txn_t          exp_q[$];
  logic [BW-1:0] preset_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            mon_beats = 0;
  bit            mem_always = 1'b0;
  bit            idle_pulse = 1'b0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Memory side and scoreboard: the expected line of a read is simply the
  // beats this memory handed out, in order; a write must present the line's
  // 64-bit slices low to high, one per accepted beat.
  initial begin : monitor
    logic          resp;
    logic [BW-1:0] data;
    logic [LW-1:0] asm_line;
    bit            active;
    bit            prev_resp;
    txn_t          t;
    asm_line  = '0;
    prev_resp = 1'b0;
    bus.burst_resp_i  = 1'b0;
    bus.burst_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mon_beats = 0;
        asm_line  = '0;
        prev_resp = 1'b0;
        bus.burst_resp_i = 1'b0;
        continue;
      end
      if (mon_beats == NB)
        chk("resp_after_last_beat", LW'(bus.line_resp_o), LW'(1));
      active = bus.burst_read_o | bus.burst_write_o;
      chk("rd_wr_exclusive", LW'(bus.burst_read_o & bus.burst_write_o), LW'(0));
      if (active) begin
        if (exp_q.size() == 0) begin
          chk("burst_without_request", LW'(exp_q.size()), LW'(1));
        end else begin
          t = exp_q[0];
          chk("burst_kind_is_write", LW'(bus.burst_write_o), LW'(t.is_wr));
          chk("burst_addr", LW'(bus.burst_addr_o), LW'({t.addr[31:5], 5'b0}));
        end
      end
      if (active) resp = mem_always ? 1'b1 : ($urandom_range(0, 2) != 0);
      else        resp = idle_pulse ? 1'($urandom_range(0, 1)) : 1'b0;
      if (active && resp && bus.burst_read_o && preset_q.size() > 0)
        data = preset_q.pop_front();
      else
        data = {$urandom, $urandom};
      bus.burst_resp_i  = resp;
      bus.burst_rdata_i = data;
      if (active && resp && exp_q.size() > 0) begin
        t = exp_q[0];
        if (mon_beats >= NB)
          chk("beat_overrun", LW'(mon_beats), LW'(NB - 1));
        else if (bus.burst_write_o)
          chk("write_beat", LW'(bus.burst_wdata_o), LW'(t.wdata[mon_beats*BW +: BW]));
        else
          asm_line[mon_beats*BW +: BW] = data;
        mon_beats++;
      end
      if (bus.line_resp_o) begin
        chk("resp_single_cycle", LW'(prev_resp), LW'(0));
        if (exp_q.size() == 0) begin
          chk("resp_without_request", LW'(exp_q.size()), LW'(1));
        end else begin
          t = exp_q.pop_front();
          chk("beats_per_line", LW'(mon_beats), LW'(NB));
          if (!t.is_wr) chk("line_rdata", bus.line_rdata_o, asm_line);
        end
        mon_beats = 0;
        asm_line  = '0;
      end
      prev_resp = bus.line_resp_o;
    end
  end

  // Called at posedge+1; holds each request until its resp is seen.
  task automatic txn(input bit rd, input bit wr, input logic [31:0] a,
                     input logic [LW-1:0] wd, output int lat);
    txn_t e;
    e.addr  = a;
    e.wdata = wd;
    if (rd) begin e.is_wr = 1'b0; exp_q.push_back(e); end
    if (wr) begin e.is_wr = 1'b1; exp_q.push_back(e); end
    bus.line_addr_i  = a;
    bus.line_wdata_i = wd;
    bus.line_read_i  = rd;
    bus.line_write_i = wr;
    lat = 0;
    while ((bus.line_read_i || bus.line_write_i) && lat < 400) begin
      @(posedge clk); #1;
      lat++;
      if (bus.line_resp_o) begin
        if (bus.line_read_i) bus.line_read_i  = 1'b0;
        else                 bus.line_write_i = 1'b0;
      end
    end
    if (bus.line_read_i || bus.line_write_i) begin
      chk("txn_pending_after_budget", LW'({bus.line_read_i, bus.line_write_i}), LW'(0));
      bus.line_read_i  = 1'b0;
      bus.line_write_i = 1'b0;
      exp_q.delete();
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_line_resp"},   LW'(bus.line_resp_o),   LW'(0));
    chk({tag, "_burst_read"},  LW'(bus.burst_read_o),  LW'(0));
    chk({tag, "_burst_write"}, LW'(bus.burst_write_o), LW'(0));
    chk({tag, "_burst_addr"},  LW'(bus.burst_addr_o),  LW'(0));
    chk({tag, "_burst_wdata"}, LW'(bus.burst_wdata_o), LW'(0));
    chk({tag, "_line_rdata"},  bus.line_rdata_o,       LW'(0));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat;
    int k;
    int waited;
    logic [LW-1:0] wline;
    bus.line_read_i  = 1'b0;
    bus.line_write_i = 1'b0;
    bus.line_addr_i  = '0;
    bus.line_wdata_i = '0;

    idle_cycles(3);
    chk_all_zero("reset");
    rst = 1'b1;

    // Stray beat handshakes while idle must not start anything.
    idle_pulse = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("idle_no_resp",  LW'(bus.line_resp_o), LW'(0));
      chk("idle_no_burst", LW'(bus.burst_read_o | bus.burst_write_o), LW'(0));
    end
    idle_pulse = 1'b0;
    idle_cycles(2);

    // Back-to-back read with known beats.
    mem_always = 1'b1;
    preset_q.push_back(64'h1111111111111111);
    preset_q.push_back(64'h2222222222222222);
    preset_q.push_back(64'h3333333333333333);
    preset_q.push_back(64'h4444444444444444);
    txn(1'b1, 1'b0, 32'h0000_1234, '0, lat);
    chk("read_latency", LW'(lat), LW'(5));
    chk("read_line_known", bus.line_rdata_o,
        256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
    chk("read_addr_aligned", LW'(bus.burst_addr_o), LW'(32'h0000_1220));
    idle_cycles(2);

    // Read with gapped beats.
    mem_always = 1'b0;
    txn(1'b1, 1'b0, 32'h0000_1234, '0, lat);
    idle_cycles(1);

    // Write of a known line with gapped beats.
    wline = 256'h0123456789ABCDEF_FEDCBA9876543210_DEADBEEFCAFEF00D_0011223344556677;
    txn(1'b0, 1'b1, 32'h8000_0040, wline, lat);
    chk("write_addr_aligned", LW'(bus.burst_addr_o), LW'(32'h8000_0040));
    idle_cycles(1);

    // Simultaneous read and write: read is served first.
    txn(1'b1, 1'b1, 32'h0000_5A7F, {8{32'hA5A5_0F0F}}, lat);
    idle_cycles(1);

    for (int n = 0; n < 40; n++) begin
      mem_always = ($urandom_range(0, 3) == 0);
      k = $urandom_range(0, 2);
      wline = {$urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom};
      txn(k != 1, k != 0, $urandom, wline, lat);
      idle_cycles($urandom_range(0, 2));
    end

    // Reset after two read beats, then a clean read.
    mem_always = 1'b1;
    idle_cycles(1);
    begin
      txn_t e;
      e.is_wr = 1'b0;
      e.addr  = 32'h0000_0BE0;
      e.wdata = '0;
      exp_q.push_back(e);
    end
    bus.line_addr_i = 32'h0000_0BE0;
    bus.line_read_i = 1'b1;
    waited = 0;
    while (mon_beats < 2 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("two_beats_before_reset", LW'(mon_beats), LW'(2));
    rst = 1'b0;
    bus.line_read_i = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    chk_all_zero("midburst_reset");
    mem_always = 1'b0;
    txn(1'b1, 1'b0, 32'h0000_0BE0, '0, lat);
    idle_cycles(3);
    chk("scoreboard_drained", LW'(exp_q.size()), LW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
